// File: rtl/sd_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : sd_pkg                                                         |
// | Purpose : Shared types, constants and helper functions for the SD-card   |
// |           SPI-mode command sequencer (sd_cmd_seq) and its CRC7 unit.     |
// | Contents: sd_cmd_state_t state enum, fill/command/CRC constants,         |
// |           sd_fixed_crc_byte() and sd_crc7_step() helpers.                |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
package sd_pkg;

    // Sequencer states; explicit 3-bit encoding.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FRAME = 3'd1,
        ST_POLL  = 3'd2,
        ST_FILL  = 3'd3,
        ST_RESP  = 3'd4
    } sd_cmd_state_t;

    localparam logic [7:0] SD_FILL_BYTE  = 8'hFF;
    localparam logic [5:0] SD_CMD0       = 6'd0;
    localparam logic [5:0] SD_CMD8       = 6'd8;
    localparam logic [5:0] SD_CMD17      = 6'd17;

    // Complete "CRC + end bit" bytes used when CRC7 is not computed.
    localparam logic [7:0] SD_CRC_CMD0   = 8'h95;
    localparam logic [7:0] SD_CRC_CMD8   = 8'h87;
    localparam logic [7:0] SD_CRC_OTHER  = 8'h01;

    // Start bit (0) and transmission bit (1) that lead every command token.
    localparam logic [1:0] SD_START_BITS = 2'b01;

    // x^7 + x^3 + 1 with the x^7 term implicit.
    localparam logic [6:0] SD_CRC7_POLY  = 7'h09;

    // Fixed trailing byte for a command index. CMD0 and CMD8 are the only
    // commands the card checks before CRC checking is switched off.
    function automatic logic [7:0] sd_fixed_crc_byte(input logic [5:0] idx);
        logic [7:0] b;
        case (idx)
            SD_CMD0: b = SD_CRC_CMD0;
            SD_CMD8: b = SD_CRC_CMD8;
            default: b = SD_CRC_OTHER;
        endcase
        return b;
    endfunction

    // Advance a CRC7 register by one byte, MSB first.
    function automatic logic [6:0] sd_crc7_step(input logic [6:0] crc,
                                                input logic [7:0] data);
        logic [6:0] c;
        logic       fb;
        c = crc;
        for (int i = 7; i >= 0; i--) begin
            fb = c[6] ^ data[i];
            c  = {c[5:0], 1'b0};
            if (fb) begin
                c = c ^ SD_CRC7_POLY;
            end
        end
        return c;
    endfunction

endpackage : sd_pkg
`default_nettype wire

// File: rtl/sd_cmd_seq_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : sd_cmd_seq_if                                                  |
// | Purpose : Bundles the upstream command/response handshake and the        |
// |           byte-level SPI master handshake of sd_cmd_seq.                 |
// | Ports   : cmd_valid/cmd_ready/cmd_index/cmd_arg  - command request       |
// |           resp_valid/resp_r1/resp_timeout        - R1 response           |
// |           spi_begin/spi_tx/spi_done/spi_rx       - SPI byte transaction  |
// |           cs_n                                   - card select           |
// | Modports: slave  - the sequencer's view                                  |
// |           master - the environment (driver logic + SPI master) view      |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
interface sd_cmd_seq_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [5:0]  cmd_index;
    logic [31:0] cmd_arg;
    logic        resp_valid;
    logic [7:0]  resp_r1;
    logic        resp_timeout;
    logic        spi_begin;
    logic [7:0]  spi_tx;
    logic        spi_done;
    logic [7:0]  spi_rx;
    logic        cs_n;

    modport slave (
        input  cmd_valid, cmd_index, cmd_arg, spi_done, spi_rx,
        output cmd_ready, resp_valid, resp_r1, resp_timeout,
               spi_begin, spi_tx, cs_n
    );

    modport master (
        output cmd_valid, cmd_index, cmd_arg, spi_done, spi_rx,
        input  cmd_ready, resp_valid, resp_r1, resp_timeout,
               spi_begin, spi_tx, cs_n
    );
endinterface : sd_cmd_seq_if
`default_nettype wire

// File: rtl/sd_crc7.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : sd_crc7                                                        |
// | Purpose : Byte-wide CRC7 accumulator (x^7+x^3+1, initial value 0).       |
// | Ports   : clk, rst_n (async, active low)                                 |
// |           clear  - restart from 0 (the byte on data is still folded in   |
// |                    when enable is also high)                             |
// |           enable - fold data into the running CRC                        |
// |           data   - byte to fold in                                       |
// |           crc    - current CRC7 value                                    |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module sd_crc7
    import sd_pkg::*;
(
    input  wire logic       clk,
    input  wire logic       rst_n,
    input  wire logic       clear,
    input  wire logic       enable,
    input  wire logic [7:0] data,
    output logic      [6:0] crc
);

    logic [6:0] crc_q;
    logic [6:0] crc_d;
    logic [6:0] w_base;

    // Clearing and folding the first byte happen in the same cycle, so the
    // update starts from zero instead of the stale register value.
    always_comb begin
        w_base = clear ? 7'd0 : crc_q;
        crc_d  = w_base;
        if (enable) begin
            crc_d = sd_crc7_step(w_base, data);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc_q <= 7'd0;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc = crc_q;

endmodule : sd_crc7
`default_nettype wire

// File: rtl/sd_cmd_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : sd_cmd_seq                                                     |
// | Purpose : SD-card SPI-mode command sequencer. Frames one command as a    |
// |           6-byte token, sends it through a byte-level SPI master, polls  |
// |           with 0xFF bytes for the R1 response (or a poll limit), sends   |
// |           trailing 0xFF bytes, releases chip select and reports R1.      |
// | Ports   : clk_800k - clock shared with the SPI master                    |
// |           rst_n    - asynchronous active-low reset                       |
// |           bus      - sd_cmd_seq_if.slave (command, response, SPI, cs_n)  |
// | Params  : MAX_POLL  - filler bytes clocked while waiting for R1          |
// |           POST_FILL - 0xFF bytes sent after R1, before cs_n rises        |
// | Macro   : SD_CRC7_EN - when defined, the last frame byte carries a CRC7  |
// |           computed over bytes 0..4; otherwise a per-command constant.    |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module sd_cmd_seq
    import sd_pkg::*;
#(
    parameter int MAX_POLL  = 8,
    parameter int POST_FILL = 1
) (
    input  wire logic     clk_800k,
    input  wire logic     rst_n,
    sd_cmd_seq_if.slave   bus
);

    localparam int POLL_W = (MAX_POLL  < 1) ? 1 : $clog2(MAX_POLL + 1);
    localparam int FILL_W = (POST_FILL < 1) ? 1 : $clog2(POST_FILL + 1);

    // ------------------------------------------------------------------
    // State and registered outputs
    // ------------------------------------------------------------------
    sd_cmd_state_t      state_q,        state_d;
    logic               cmd_ready_q,    cmd_ready_d;
    logic [5:0]         idx_q,          idx_d;
    logic [31:0]        arg_q,          arg_d;
    logic [2:0]         byte_cnt_q,     byte_cnt_d;
    logic [POLL_W-1:0]  poll_cnt_q,     poll_cnt_d;
    logic [FILL_W-1:0]  fill_cnt_q,     fill_cnt_d;
    logic [7:0]         r1_q,           r1_d;
    logic               timeout_q,      timeout_d;
    logic               resp_valid_q,   resp_valid_d;
    logic [7:0]         resp_r1_q,      resp_r1_d;
    logic               resp_timeout_q, resp_timeout_d;
    logic               spi_begin_q,    spi_begin_d;
    logic [7:0]         spi_tx_q,       spi_tx_d;
    logic               cs_n_q,         cs_n_d;

    logic               w_handshake;
    logic               w_poll_max;
    logic [7:0]         w_crc_byte;
    logic [7:0]         w_next_frame_byte;

    assign w_handshake = (state_q == ST_IDLE) && cmd_ready_q && bus.cmd_valid;
    assign w_poll_max  = (poll_cnt_q >= POLL_W'(MAX_POLL));

    // ------------------------------------------------------------------
    // Trailing frame byte: computed CRC7 or per-command constant
    // ------------------------------------------------------------------
`ifdef SD_CRC7_EN
    logic       w_crc_clear;
    logic       w_crc_en;
    logic [7:0] w_crc_data;
    logic [6:0] w_crc;

    // Fold each of bytes 0..4 in at the moment it is issued; by the time
    // byte 5 is chosen the register already covers the whole header.
    assign w_crc_clear = w_handshake;
    assign w_crc_en    = w_handshake ||
                         ((state_q == ST_FRAME) && bus.spi_done &&
                          (byte_cnt_q < 3'd4));
    assign w_crc_data  = spi_tx_d;

    sd_crc7 u_crc7 (
        .clk    (clk_800k),
        .rst_n  (rst_n),
        .clear  (w_crc_clear),
        .enable (w_crc_en),
        .data   (w_crc_data),
        .crc    (w_crc)
    );

    assign w_crc_byte = {w_crc, 1'b1};
`else
    assign w_crc_byte = sd_fixed_crc_byte(idx_q);
`endif

    // Byte that follows the one currently in flight (byte_cnt_q).
    always_comb begin
        case (byte_cnt_q)
            3'd0:    w_next_frame_byte = arg_q[31:24];
            3'd1:    w_next_frame_byte = arg_q[23:16];
            3'd2:    w_next_frame_byte = arg_q[15:8];
            3'd3:    w_next_frame_byte = arg_q[7:0];
            default: w_next_frame_byte = w_crc_byte;
        endcase
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d        = state_q;
        cmd_ready_d    = 1'b0;
        idx_d          = idx_q;
        arg_d          = arg_q;
        byte_cnt_d     = byte_cnt_q;
        poll_cnt_d     = poll_cnt_q;
        fill_cnt_d     = fill_cnt_q;
        r1_d           = r1_q;
        timeout_d      = timeout_q;
        resp_valid_d   = 1'b0;
        resp_r1_d      = resp_r1_q;
        resp_timeout_d = resp_timeout_q;
        spi_begin_d    = 1'b0;
        spi_tx_d       = spi_tx_q;
        cs_n_d         = cs_n_q;

        case (state_q)
            ST_IDLE: begin
                cmd_ready_d = 1'b1;
                cs_n_d      = 1'b1;
                if (w_handshake) begin
                    idx_d       = bus.cmd_index;
                    arg_d       = bus.cmd_arg;
                    byte_cnt_d  = 3'd0;
                    poll_cnt_d  = '0;
                    fill_cnt_d  = '0;
                    r1_d        = SD_FILL_BYTE;
                    timeout_d   = 1'b0;
                    cmd_ready_d = 1'b0;
                    cs_n_d      = 1'b0;
                    // Byte 0 is launched straight from the handshake so it
                    // appears together with the falling cs_n.
                    spi_begin_d = 1'b1;
                    spi_tx_d    = {SD_START_BITS, bus.cmd_index};
                    state_d     = ST_FRAME;
                end
            end

            ST_FRAME: begin
                if (bus.spi_done) begin
                    spi_begin_d = 1'b1;
                    if (byte_cnt_q == 3'd5) begin
                        spi_tx_d   = SD_FILL_BYTE;
                        poll_cnt_d = POLL_W'(1);
                        state_d    = ST_POLL;
                    end else begin
                        spi_tx_d   = w_next_frame_byte;
                        byte_cnt_d = byte_cnt_q + 3'd1;
                    end
                end
            end

            ST_POLL: begin
                if (bus.spi_done) begin
                    if (!bus.spi_rx[7] || w_poll_max) begin
                        // A set MSB at the limit means no R1 was seen.
                        timeout_d = bus.spi_rx[7];
                        r1_d      = bus.spi_rx[7] ? SD_FILL_BYTE : bus.spi_rx;
                        if (POST_FILL == 0) begin
                            cs_n_d  = 1'b1;
                            state_d = ST_RESP;
                        end else begin
                            fill_cnt_d  = FILL_W'(1);
                            spi_begin_d = 1'b1;
                            spi_tx_d    = SD_FILL_BYTE;
                            state_d     = ST_FILL;
                        end
                    end else begin
                        poll_cnt_d  = poll_cnt_q + POLL_W'(1);
                        spi_begin_d = 1'b1;
                        spi_tx_d    = SD_FILL_BYTE;
                    end
                end
            end

            ST_FILL: begin
                if (bus.spi_done) begin
                    if (fill_cnt_q >= FILL_W'(POST_FILL)) begin
                        cs_n_d  = 1'b1;
                        state_d = ST_RESP;
                    end else begin
                        fill_cnt_d  = fill_cnt_q + FILL_W'(1);
                        spi_begin_d = 1'b1;
                        spi_tx_d    = SD_FILL_BYTE;
                    end
                end
            end

            ST_RESP: begin
                // cs_n is already high here; the response follows one cycle
                // later, together with cmd_ready for the next command.
                resp_valid_d   = 1'b1;
                resp_r1_d      = r1_q;
                resp_timeout_d = timeout_q;
                cmd_ready_d    = 1'b1;
                state_d        = ST_IDLE;
            end

            default: begin
                cs_n_d  = 1'b1;
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_800k or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            cmd_ready_q    <= 1'b0;
            idx_q          <= 6'd0;
            arg_q          <= 32'd0;
            byte_cnt_q     <= 3'd0;
            poll_cnt_q     <= '0;
            fill_cnt_q     <= '0;
            r1_q           <= SD_FILL_BYTE;
            timeout_q      <= 1'b0;
            resp_valid_q   <= 1'b0;
            resp_r1_q      <= 8'h00;
            resp_timeout_q <= 1'b0;
            spi_begin_q    <= 1'b0;
            spi_tx_q       <= SD_FILL_BYTE;
            cs_n_q         <= 1'b1;
        end else begin
            state_q        <= state_d;
            cmd_ready_q    <= cmd_ready_d;
            idx_q          <= idx_d;
            arg_q          <= arg_d;
            byte_cnt_q     <= byte_cnt_d;
            poll_cnt_q     <= poll_cnt_d;
            fill_cnt_q     <= fill_cnt_d;
            r1_q           <= r1_d;
            timeout_q      <= timeout_d;
            resp_valid_q   <= resp_valid_d;
            resp_r1_q      <= resp_r1_d;
            resp_timeout_q <= resp_timeout_d;
            spi_begin_q    <= spi_begin_d;
            spi_tx_q       <= spi_tx_d;
            cs_n_q         <= cs_n_d;
        end
    end

    assign bus.cmd_ready    = cmd_ready_q;
    assign bus.resp_valid   = resp_valid_q;
    assign bus.resp_r1      = resp_r1_q;
    assign bus.resp_timeout = resp_timeout_q;
    assign bus.spi_begin    = spi_begin_q;
    assign bus.spi_tx       = spi_tx_q;
    assign bus.cs_n         = cs_n_q;

endmodule : sd_cmd_seq
`default_nettype wire

// File: tb/tb_sd_cmd_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_sd_cmd_seq                                                  |
// | Purpose : Self-checking bench for sd_cmd_seq (MAX_POLL=8, POST_FILL=1).  |
// |           A scoreboard queue holds the expected SPI byte stream and the  |
// |           expected responses; an SPI responder and a response monitor    |
// |           pop and compare. Honours SD_CRC7_EN for the CMD17 CRC byte.    |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module tb_sd_cmd_seq;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sd_cmd_seq_if bus ();

    sd_cmd_seq #(
        .MAX_POLL  (8),
        .POST_FILL (1)
    ) dut (
        .clk_800k (clk),
        .rst_n    (rst_n),
        .bus      (bus)
    );

`ifdef SD_CRC7_EN
    localparam logic [7:0] CMD17_CRC = 8'h55;
`else
    localparam logic [7:0] CMD17_CRC = 8'h01;
`endif

    int          checks     = 0;
    int          errors     = 0;
    logic [7:0]  exp_tx[$];
    logic [8:0]  exp_resp[$];   // {timeout, r1}
    int          byte_num   = 0;
    int          r1_at      = 0;
    logic [7:0]  r1_val     = 8'h00;
    int          resp_seen  = 0;
    int          resp_exp_n = 0;
    logic [2:0]  cs_hist    = 3'b111;
    logic [7:0]  tx_seen;
    logic [8:0]  resp_e;

    task automatic chk(input string tag, input logic [39:0] obs,
                       input logic [39:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // SPI master model: accepts a byte on spi_begin, holds it for two
    // cycles, then returns one spi_done pulse with the card's byte.
    initial begin
        bus.spi_done = 1'b0;
        bus.spi_rx   = 8'hFF;
        forever begin
            @(negedge clk);
            bus.spi_done = 1'b0;
            if (bus.cs_n) byte_num = 0;
            if (bus.spi_begin) begin
                tx_seen  = bus.spi_tx;
                byte_num = byte_num + 1;
                if (exp_tx.size() == 0)
                    chk("spi_byte_expected", 40'(exp_tx.size() != 0), 40'd1);
                else
                    chk("spi_tx", 40'(tx_seen), 40'(exp_tx.pop_front()));
                for (int k = 0; k < 2; k++) begin
                    @(negedge clk);
                    if (rst_n) begin
                        chk("spi_begin_single", 40'(bus.spi_begin), 40'd0);
                        chk("spi_tx_stable", 40'(bus.spi_tx), 40'(tx_seen));
                    end
                end
                bus.spi_rx   = (r1_at != 0 && byte_num == 6 + r1_at) ? r1_val : 8'hFF;
                bus.spi_done = 1'b1;
            end
        end
    end

    // Response monitor.
    initial begin
        forever begin
            @(negedge clk);
            cs_hist = {cs_hist[1:0], bus.cs_n};
            if (bus.resp_valid) begin
                resp_seen++;
                if (exp_resp.size() == 0) begin
                    chk("resp_expected", 40'(exp_resp.size() != 0), 40'd1);
                end else begin
                    resp_e = exp_resp.pop_front();
                    chk("resp_r1", 40'(bus.resp_r1), 40'(resp_e[7:0]));
                    chk("resp_timeout", 40'(bus.resp_timeout), 40'(resp_e[8]));
                end
                chk("cs_n_rise_then_resp", 40'(cs_hist), 40'(3'b011));
                chk("all_bytes_sent", 40'(exp_tx.size()), 40'd0);
            end
        end
    end

    task automatic push_frame(input logic [5:0] idx, input logic [31:0] arg,
                              input logic [7:0] crc);
        exp_tx.push_back({2'b01, idx});
        exp_tx.push_back(arg[31:24]);
        exp_tx.push_back(arg[23:16]);
        exp_tx.push_back(arg[15:8]);
        exp_tx.push_back(arg[7:0]);
        exp_tx.push_back(crc);
    endtask

    task automatic wait_resp();
        int n;
        n = 0;
        while (!bus.resp_valid && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("resp_within_bound", 40'(bus.resp_valid), 40'd1);
    endtask

    // poll_at = 0 means the card never answers.
    task automatic run_cmd(input logic [5:0] idx, input logic [31:0] arg,
                           input logic [7:0] crc, input int poll_at,
                           input logic [7:0] r1, input bit hold);
        int polls;
        polls = (poll_at == 0) ? 8 : poll_at;
        push_frame(idx, arg, crc);
        for (int i = 0; i < polls + 1; i++) exp_tx.push_back(8'hFF);
        exp_resp.push_back((poll_at == 0) ? {1'b1, 8'hFF} : {1'b0, r1});
        resp_exp_n++;
        r1_at         = poll_at;
        r1_val        = r1;
        bus.cmd_index = idx;
        bus.cmd_arg   = arg;
        bus.cmd_valid = 1'b1;
        @(negedge clk);
        chk("accept_cs_n", 40'(bus.cs_n), 40'd0);
        chk("accept_spi_begin", 40'(bus.spi_begin), 40'd1);
        chk("accept_cmd_ready", 40'(bus.cmd_ready), 40'd0);
        if (!hold) bus.cmd_valid = 1'b0;
        wait_resp();
        bus.cmd_valid = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int n;
        bus.cmd_valid = 1'b0;
        bus.cmd_index = 6'd0;
        bus.cmd_arg   = 32'd0;
        repeat (3) @(negedge clk);

        // Reset state.
        chk("rst_cmd_ready", 40'(bus.cmd_ready), 40'd0);
        chk("rst_resp_valid", 40'(bus.resp_valid), 40'd0);
        chk("rst_resp_r1", 40'(bus.resp_r1), 40'h00);
        chk("rst_resp_timeout", 40'(bus.resp_timeout), 40'd0);
        chk("rst_spi_begin", 40'(bus.spi_begin), 40'd0);
        chk("rst_spi_tx", 40'(bus.spi_tx), 40'hFF);
        chk("rst_cs_n", 40'(bus.cs_n), 40'd1);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_release", 40'(bus.cmd_ready), 40'd1);
        chk("idle_cs_n", 40'(bus.cs_n), 40'd1);

        // CMD0, R1 on the 2nd poll byte: 9 bytes total.
        run_cmd(6'd0, 32'h0, 8'h95, 2, 8'h01, 1'b0);
        // CMD8, R1 on the 1st poll byte.
        run_cmd(6'd8, 32'h0000_01AA, 8'h87, 1, 8'h01, 1'b0);
        // CMD17, immediate R1 = 0x00.
        run_cmd(6'd17, 32'h0, CMD17_CRC, 1, 8'h00, 1'b0);
        // MISO stuck high: 8 poll bytes then timeout.
        run_cmd(6'd0, 32'h0, 8'h95, 0, 8'h00, 1'b0);
        // R1 on the last allowed poll byte is still a valid answer.
        run_cmd(6'd0, 32'h0, 8'h95, 8, 8'h05, 1'b0);

        // cmd_valid held through a busy command: a single frame and response.
        run_cmd(6'd8, 32'h0000_01AA, 8'h87, 1, 8'h01, 1'b1);
        repeat (20) @(negedge clk);
        chk("held_valid_single_resp", 40'(resp_seen), 40'(resp_exp_n));
        chk("held_valid_no_extra_bytes", 40'(exp_tx.size()), 40'd0);

        // Reset during byte 3 of the frame.
        push_frame(6'd17, 32'h1234_5678, CMD17_CRC);
        r1_at         = 1;
        r1_val        = 8'h00;
        bus.cmd_index = 6'd17;
        bus.cmd_arg   = 32'h1234_5678;
        bus.cmd_valid = 1'b1;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        n = 0;
        while (byte_num < 4 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("reached_frame_byte3", 40'(byte_num), 40'd4);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_cs_n", 40'(bus.cs_n), 40'd1);
        chk("async_rst_spi_begin", 40'(bus.spi_begin), 40'd0);
        chk("async_rst_cmd_ready", 40'(bus.cmd_ready), 40'd0);
        repeat (6) @(negedge clk);
        exp_tx.delete();
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_abort", 40'(bus.cmd_ready), 40'd1);
        repeat (10) @(negedge clk);
        chk("abort_no_resp", 40'(resp_seen), 40'(resp_exp_n));
        chk("abort_cs_n_idle", 40'(bus.cs_n), 40'd1);

        // Fresh CMD0 after the abort.
        run_cmd(6'd0, 32'h0, 8'h95, 1, 8'h01, 1'b0);
        repeat (5) @(negedge clk);
        chk("total_responses", 40'(resp_seen), 40'(resp_exp_n));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule : tb_sd_cmd_seq
`default_nettype wire
